// File: rtl/text_write_ctrl.sv
// text_write_ctrl: turns UART column/row/char/terminator frames into screen-buffer writes.
// Define CLEAR_CMD_EN to compile in the 8'hFF clear-screen sweep and its one-byte hold register.
module text_write_ctrl #(
  parameter int unsigned N_COL          = 160,
  parameter int unsigned N_ROW          = 60,
  parameter logic [6:0]  CLEAR_CHAR     = 7'h20,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       wr_i,
  input  logic [7:0] data_i,
  output logic       wr_en_o,
  output logic [7:0] col_w_o,
  output logic [5:0] row_w_o,
  output logic [6:0] din_o,
  output logic       busy_o,
  output logic       overrun_o
);

  localparam logic [7:0]  NCol        = 8'(N_COL);
  localparam logic [5:0]  NRow        = 6'(N_ROW);
  localparam bit          TimeoutEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

`ifdef CLEAR_CMD_EN
  localparam logic [7:0]  ColMax      = 8'(N_COL - 1);
  localparam logic [5:0]  RowMax      = 6'(N_ROW - 1);
  typedef enum logic [2:0] {StCol, StRow, StChar, StTerm, StClear} state_e;
`else
  typedef enum logic [1:0] {StCol, StRow, StChar, StTerm} state_e;
`endif

  state_e      state_q, state_d;
  logic        wr_d_q, wr_d_d;
  logic [7:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic [31:0] tmo_q, tmo_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  col_w_q, col_w_d;
  logic [5:0]  row_w_q, row_w_d;
  logic [6:0]  din_q, din_d;

  logic        new_ev, ev, counting, timeout;
  logic [7:0]  ev_byte, col_red;
  logic [5:0]  row_raw, row_red;

`ifdef CLEAR_CMD_EN
  logic        busy_q, busy_d;
  logic        ovr_q, ovr_d;
  logic        hold_vld_q, hold_vld_d;
  logic [7:0]  hold_byte_q, hold_byte_d;
`else
  logic        unused_clear_char;
  assign unused_clear_char = ^CLEAR_CHAR;
`endif

  always_comb begin
    wr_d_d  = wr_i;
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    wr_en_d = 1'b0;
    col_w_d = col_w_q;
    row_w_d = row_w_q;
    din_d   = din_q;
    new_ev  = wr_i & ~wr_d_q;
    ev      = new_ev;
    ev_byte = data_i;
`ifdef CLEAR_CMD_EN
    busy_d      = 1'b0;
    ovr_d       = ovr_q;
    hold_vld_d  = hold_vld_q;
    hold_byte_d = hold_byte_q;
    if (state_q == StClear) begin
      // Bytes arriving during a sweep are parked; only one slot, extras are lost.
      ev = 1'b0;
      if (new_ev) begin
        if (hold_vld_q) begin
          ovr_d = 1'b1;
        end else begin
          hold_vld_d  = 1'b1;
          hold_byte_d = data_i;
        end
      end
    end else if (hold_vld_q) begin
      // Held byte goes first; a simultaneous new byte takes its place in the slot.
      ev         = 1'b1;
      ev_byte    = hold_byte_q;
      hold_vld_d = new_ev;
      if (new_ev) hold_byte_d = data_i;
    end
`endif

    col_red  = (ev_byte >= NCol) ? ev_byte - NCol : ev_byte;
    row_raw  = ev_byte[5:0];
    row_red  = (row_raw >= NRow) ? row_raw - NRow : row_raw;
    counting = (state_q == StRow) || (state_q == StChar) || (state_q == StTerm);
    timeout  = TimeoutEn && counting && !ev && (tmo_q == TimeoutLast);

    if (ev || !counting || !TimeoutEn || timeout) tmo_d = '0;
    else                                          tmo_d = tmo_q + 32'd1;

    case (state_q)
      StCol: begin
        if (ev) begin
          state_d = StRow;
          col_d   = col_red;
`ifdef CLEAR_CMD_EN
          if (ev_byte == 8'hFF) begin
            state_d = StClear;
            col_d   = col_q;
            wr_en_d = 1'b1;
            busy_d  = 1'b1;
            col_w_d = '0;
            row_w_d = '0;
            din_d   = CLEAR_CHAR;
          end
`endif
        end
      end
      StRow: begin
        if (ev) begin
          state_d = StChar;
          row_d   = row_red;
        end else if (timeout) begin
          state_d = StCol;
        end
      end
      StChar: begin
        if (ev) begin
          state_d = StTerm;
          wr_en_d = 1'b1;
          col_w_d = col_q;
          row_w_d = row_q;
          din_d   = ev_byte[6:0];
        end else if (timeout) begin
          state_d = StCol;
        end
      end
      StTerm: begin
        if (ev || timeout) state_d = StCol;
      end
`ifdef CLEAR_CMD_EN
      StClear: begin
        // Raster sweep using the output address registers as the cursor.
        if (col_w_q == ColMax && row_w_q == RowMax) begin
          state_d = StCol;
        end else begin
          wr_en_d = 1'b1;
          busy_d  = 1'b1;
          din_d   = CLEAR_CHAR;
          if (col_w_q == ColMax) begin
            col_w_d = '0;
            row_w_d = row_w_q + 6'd1;
          end else begin
            col_w_d = col_w_q + 8'd1;
          end
        end
      end
`endif
      default: state_d = StCol;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StCol;
      wr_d_q      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      tmo_q       <= '0;
      wr_en_q     <= 1'b0;
      col_w_q     <= '0;
      row_w_q     <= '0;
      din_q       <= '0;
`ifdef CLEAR_CMD_EN
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_byte_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_d_q      <= wr_d_d;
      col_q       <= col_d;
      row_q       <= row_d;
      tmo_q       <= tmo_d;
      wr_en_q     <= wr_en_d;
      col_w_q     <= col_w_d;
      row_w_q     <= row_w_d;
      din_q       <= din_d;
`ifdef CLEAR_CMD_EN
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
      hold_vld_q  <= hold_vld_d;
      hold_byte_q <= hold_byte_d;
`endif
    end
  end

  assign wr_en_o   = wr_en_q;
  assign col_w_o   = col_w_q;
  assign row_w_o   = row_w_q;
  assign din_o     = din_q;
`ifdef CLEAR_CMD_EN
  assign busy_o    = busy_q;
  assign overrun_o = ovr_q;
`else
  assign busy_o    = 1'b0;
  assign overrun_o = 1'b0;
`endif

endmodule
